// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, rounding constant and the fixed 32-tap coefficient set (signed Q4.16).
package fir_pkg;
    localparam int TAPS       = 32;
    localparam int DW         = 16;
    localparam int CW         = 20;
    localparam int ACCW       = 41;
    localparam int PW         = DW + CW;
    localparam int FRAC_SHIFT = 16;
    localparam int GROUPS     = 4;
    localparam int GSZ        = TAPS / GROUPS;
    localparam logic signed [ACCW-1:0] RND_HALF =
        {{(ACCW-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
    // Symmetric low-pass; DC gain is about 1.19, so full-scale input overflows Q8.8.
    localparam logic signed [CW-1:0] COEF [0:TAPS-1] = '{
        -20'sd300, -20'sd500, -20'sd400,  20'sd0,    20'sd600,  20'sd1200, 20'sd1700, 20'sd2300,
         20'sd2900, 20'sd3500, 20'sd4000, 20'sd4400, 20'sd4700, 20'sd4900, 20'sd5000, 20'sd5037,
         20'sd5037, 20'sd5000, 20'sd4900, 20'sd4700, 20'sd4400, 20'sd4000, 20'sd3500, 20'sd2900,
         20'sd2300, 20'sd1700, 20'sd1200, 20'sd600,  20'sd0,   -20'sd400, -20'sd500, -20'sd300
    };
endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: Q?.24 accumulator to Q8.8 with round half-up; clamps when FIR_SAT_EN is defined,
// otherwise wraps to the low DW bits.
module fir_round_sat
    import fir_pkg::*;
(
    input  logic signed [ACCW-1:0] acc_i,
    output logic        [DW-1:0]   y_o
);
    localparam int SW = ACCW - FRAC_SHIFT;
    logic signed [ACCW-1:0] rnd;
    assign rnd = acc_i + RND_HALF;
`ifdef FIR_SAT_EN
    localparam logic signed [SW-1:0] MAX_V = SW'((1 << (DW-1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;
    logic signed [SW-1:0] shr;
    assign shr = SW'(rnd >>> FRAC_SHIFT);
    assign y_o = (shr > MAX_V) ? {1'b0, {(DW-1){1'b1}}} :
                 (shr < MIN_V) ? {1'b1, {(DW-1){1'b0}}} : DW'(shr);
`else
    assign y_o = DW'(rnd >>> FRAC_SHIFT);
`endif
endmodule

// File: rtl/fir_filter.sv
// fir_filter: 32-tap direct-form FIR, one sample per clock, 4-cycle latency, no stall.
// Optional output saturation via FIR_SAT_EN (see fir_round_sat).
module fir_filter
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          data_valid,
    input  logic [DW-1:0] data,
    output logic          fir_valid,
    output logic [DW-1:0] fir_d
);
    logic signed [DW-1:0]   tap_q  [TAPS];
    logic signed [PW-1:0]   prod_q [TAPS];
    logic signed [PW-1:0]   prod_d [TAPS];
    logic signed [ACCW-1:0] grp_q  [GROUPS];
    logic signed [ACCW-1:0] grp_d  [GROUPS];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [DW-1:0]          out_q, out_d, rs_y;
    logic [3:0]             vld_q;
    logic                   fir_valid_q;

    always_comb begin
        for (int k = 0; k < TAPS; k++) prod_d[k] = PW'(tap_q[k]) * PW'(COEF[k]);
        for (int g = 0; g < GROUPS; g++) begin
            grp_d[g] = '0;
            for (int j = 0; j < GSZ; j++) grp_d[g] = grp_d[g] + ACCW'(prod_q[g*GSZ+j]);
        end
        acc_d = '0;
        for (int g = 0; g < GROUPS; g++) acc_d = acc_d + grp_q[g];
        out_d = vld_q[3] ? rs_y : out_q;
    end

    fir_round_sat u_round_sat (
        .acc_i (acc_q),
        .y_o   (rs_y)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k]  <= '0;
                prod_q[k] <= '0;
            end
            for (int g = 0; g < GROUPS; g++) grp_q[g] <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            vld_q       <= '0;
            fir_valid_q <= 1'b0;
        end else begin
            if (data_valid) begin
                tap_q[0] <= data;
                for (int k = 1; k < TAPS; k++) tap_q[k] <= tap_q[k-1];
            end
            prod_q      <= prod_d;
            grp_q       <= grp_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            vld_q       <= {vld_q[2:0], data_valid};
            fir_valid_q <= vld_q[3];
        end
    end

    assign fir_valid = fir_valid_q;
    assign fir_d     = out_q;
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: table-driven directed vectors against a convolution model, plus hand sequences
// for mid-stream reset and the downstream 16-sample collector. Honours FIR_SAT_EN.
module tb_fir_filter;
    import fir_pkg::*;

    typedef struct {
        logic        dv;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_valid = 1'b0;
    logic [15:0] data = '0;
    logic        fir_valid;
    logic [15:0] fir_d;

    vec_t        vec [0:99];
    logic [15:0] mres [0:99];
    int          hist [0:31];
    int          total = 0;
    int          bad = 0;
    int          nvec = 0;
    bit          coll_en = 1'b0;
    int          coll_cnt = 0;
    int          coll_pulses = 0;
    logic [15:0] coll_buf [0:15];
    logic [15:0] coll_exp [0:15];

    fir_filter dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data       (data),
        .fir_valid  (fir_valid),
        .fir_d      (fir_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_out();
        longint acc = 0;
        longint r;
        for (int k = 0; k < TAPS; k++) acc += longint'(hist[k]) * longint'(COEF[k]);
        r = (acc + 64'sd32768) >>> 16;
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return 16'(r);
    endfunction

    task automatic add(input logic dv, input logic [15:0] d);
        vec[nvec].dv = dv;
        vec[nvec].d  = d;
        nvec++;
    endtask

    task automatic fill();
        logic [15:0] last = '0;
        for (int k = 0; k < TAPS; k++) hist[k] = 0;
        for (int j = 0; j < nvec; j++) begin
            if (vec[j].dv) begin
                for (int k = TAPS-1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'($signed(vec[j].d));
            end
            mres[j] = model_out();
        end
        for (int i = 0; i < nvec; i++) begin
            vec[i].ev = (i >= 4) ? vec[i-4].dv : 1'b0;
            if (vec[i].ev) last = mres[i-4];
            vec[i].ed = last;
        end
    endtask

    task automatic step(input logic dv, input logic [15:0] d);
        @(negedge clk);
        data_valid = dv;
        data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_valid", 16'(fir_valid), 16'h0000);
        chk("reset_d", fir_d, 16'h0000);
    endtask

    task automatic run(input string nm);
        fill();
        for (int i = 0; i < nvec; i++) begin
            step(vec[i].dv, vec[i].d);
            chk($sformatf("%s_v[%0d]", nm, i), 16'(fir_valid), 16'(vec[i].ev));
            chk($sformatf("%s_d[%0d]", nm, i), fir_d, vec[i].ed);
            if (coll_en) begin
                if (fir_valid) begin
                    coll_buf[coll_cnt] = fir_d;
                    coll_exp[coll_cnt] = vec[i].ed;
                    coll_cnt++;
                    if (coll_cnt == 16) begin
                        coll_pulses++;
                        coll_cnt = 0;
                        for (int w = 0; w < 16; w++)
                            chk($sformatf("coll_word[%0d]", w), coll_buf[w], coll_exp[w]);
                    end
                end else coll_cnt = 0;
            end
        end
        data_valid = 1'b0;
    endtask

    initial begin
        // 1 impulse
        do_reset();
        nvec = 0;
        add(1'b1, 16'h0100);
        for (int i = 0; i < 40; i++) add(1'b1, 16'h0000);
        run("imp");
        chk("imp_k0", vec[4].ed, 16'hFFFF);
        chk("imp_k1", vec[5].ed, 16'hFFFE);
        chk("imp_k15", vec[19].ed, 16'h0014);
        chk("imp_tail", vec[40].ed, 16'h0000);

        // 2 DC
        do_reset();
        nvec = 0;
        for (int i = 0; i < 64; i++) add(1'b1, 16'h0100);
        for (int i = 0; i < 4; i++) add(1'b0, 16'h0000);
        run("dc");
        chk("dc_final", fir_d, 16'h0131);

        // 3 gap 1,1,0,1: idle data must not enter the tap line
        do_reset();
        nvec = 0;
        add(1'b1, 16'h0100);
        add(1'b1, 16'h0200);
        add(1'b0, 16'h7777);
        add(1'b1, 16'h0300);
        for (int i = 0; i < 4; i++) add(1'b0, 16'h0000);
        run("gap");
        chk("gap_hold", vec[6].ed, 16'hFFFC);
        chk("gap_after", vec[7].ed, 16'hFFF7);

        // 4 saturation / wrap
        do_reset();
        nvec = 0;
        for (int i = 0; i < 40; i++) add(1'b1, 16'h7FFF);
        for (int i = 0; i < 4; i++) add(1'b0, 16'h0000);
        run("sat");
`ifdef FIR_SAT_EN
        chk("sat_final", fir_d, 16'h7FFF);
`else
        chk("wrap_final", fir_d, 16'h987C);
`endif

        // 5 reset mid-stream
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 16'h0100);
        chk("pre_rst_valid", 16'(fir_valid), 16'h0001);
        @(negedge clk);
        data_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 16'(fir_valid), 16'h0000);
        chk("midrst_d", fir_d, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 16'h0100);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("post_rst_quiet[%0d]", i), 16'(fir_valid), 16'h0000);
            step(1'b1, 16'h0000);
        end
        chk("post_rst_v", 16'(fir_valid), 16'h0001);
        chk("post_rst_k0", fir_d, 16'hFFFF);
        step(1'b1, 16'h0000);
        chk("post_rst_k1", fir_d, 16'hFFFE);
        data_valid = 1'b0;

        // 6 downstream collector: 20 back-to-back outputs give exactly one 16-word frame
        do_reset();
        nvec = 0;
        for (int i = 0; i < 20; i++) add(1'b1, 16'(i * 397 - 3000));
        for (int i = 0; i < 4; i++) add(1'b0, 16'h0000);
        coll_en = 1'b1;
        run("coll");
        coll_en = 1'b0;
        chk("coll_pulses", 16'(coll_pulses), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
